// File: rtl/dad_mem_pkg.sv
// Shared constants for the MEM-stage data/stack memory: default sizes,
// sticky error bit positions and the output port state encoding.
package dad_mem_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 12;
  localparam int SW_DEF = 10;

  localparam int ERR_OVF  = 0;
  localparam int ERR_UNF  = 1;
  localparam int ERR_DROP = 2;

  // The state bit doubles as saida_valid.
  typedef enum logic {
    OP_IDLE = 1'b0,
    OP_FULL = 1'b1
  } op_state_e;

endpackage

// File: rtl/dad_mem_ram.sv
// Single-port synchronous RAM: registered read-before-write, per-byte write
// strobes, read register cleared by reset and held while re is low.
module dad_mem_ram #(
  parameter int DW = 32,
  parameter int AW = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            re,
  input  logic            we,
  input  logic [DW/8-1:0] be,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata
);

  localparam int DEPTH = 2**AW;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q, rdata_d;

  // Writes are suppressed during reset so a request in a reset cycle is lost.
  always_ff @(posedge clk) begin
    if (rst_n && we) begin
      for (int b = 0; b < DW/8; b++) begin
        if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dad_mem_stack.sv
// MEM-stage memory: data RAM, hardware stack and handshaked output port.
// Define DAD_MEM_BYTE_EN to add the be port for byte-lane data RAM writes.
module dad_mem_stack
  import dad_mem_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int SW = SW_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [AW-1:0]   address,
  input  logic [DW-1:0]   D_escrita,
  input  logic            write,
  input  logic            read,
  input  logic            push,
  input  logic            pop,
  input  logic            otflag,
  input  logic            saida_ack,
`ifdef DAD_MEM_BYTE_EN
  input  logic [DW/8-1:0] be,
`endif
  output logic [DW-1:0]   dados_lidos,
  output logic [DW-1:0]   dados_stack,
  output logic [DW-1:0]   saida,
  output logic            saida_valid,
  output logic [SW:0]     sp,
  output logic            stack_full,
  output logic            stack_empty,
  output logic [2:0]      err
);

  localparam logic [SW:0] SP_MAX = {1'b1, {SW{1'b0}}};
  localparam logic [SW:0] SP_ONE = (SW+1)'(1);

  logic [SW:0]     sp_q, sp_d, sp_dec;
  logic [2:0]      err_q, err_d;
  logic            stk_full, stk_empty, pop_ok, push_ok;
  logic [SW-1:0]   stk_addr;
  logic [DW/8-1:0] ram_be;
  op_state_e       op_state_q;
  logic [DW-1:0]   saida_q;

`ifdef DAD_MEM_BYTE_EN
  assign ram_be = be;
`else
  assign ram_be = '1;
`endif

  dad_mem_ram #(.DW(DW), .AW(AW)) u_data_ram (
    .clk   (clock),
    .rst_n (reset),
    .re    (read),
    .we    (write),
    .be    (ram_be),
    .addr  (address),
    .wdata (D_escrita),
    .rdata (dados_lidos)
  );

  // A simultaneous push+pop on a non-empty stack rewrites the top slot
  // while the read-before-write port returns the old top.
  always_comb begin
    stk_full  = (sp_q == SP_MAX);
    stk_empty = (sp_q == '0);
    pop_ok    = pop & ~stk_empty;
    push_ok   = push & (~stk_full | pop_ok);
    sp_dec    = sp_q - SP_ONE;
    stk_addr  = pop_ok ? sp_dec[SW-1:0] : sp_q[SW-1:0];

    sp_d = sp_q;
    if (push_ok && !pop_ok)      sp_d = sp_q + SP_ONE;
    else if (pop_ok && !push_ok) sp_d = sp_dec;

    err_d = err_q;
    if (push && !pop && stk_full) err_d[ERR_OVF] = 1'b1;
    if (pop && stk_empty)         err_d[ERR_UNF] = 1'b1;
    if (otflag && !saida_ack && op_state_q == OP_FULL) err_d[ERR_DROP] = 1'b1;
  end

  dad_mem_ram #(.DW(DW), .AW(SW)) u_stack_ram (
    .clk   (clock),
    .rst_n (reset),
    .re    (pop_ok),
    .we    (push_ok),
    .be    ('1),
    .addr  (stk_addr),
    .wdata (D_escrita),
    .rdata (dados_stack)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      sp_q  <= '0;
      err_q <= '0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      op_state_q <= OP_IDLE;
      saida_q    <= '0;
    end else begin
      case (op_state_q)
        OP_IDLE: begin
          if (otflag) begin
            saida_q    <= D_escrita;
            op_state_q <= OP_FULL;
          end
        end
        OP_FULL: begin
          if (saida_ack) begin
            if (otflag) saida_q    <= D_escrita;
            else        op_state_q <= OP_IDLE;
          end
        end
        default: op_state_q <= OP_IDLE;
      endcase
    end
  end

  assign saida       = saida_q;
  assign saida_valid = (op_state_q == OP_FULL);
  assign sp          = sp_q;
  assign stack_full  = stk_full;
  assign stack_empty = stk_empty;
  assign err         = err_q;

endmodule

// File: tb/tb_dad_mem_stack.sv
// Directed bench for dad_mem_stack with a 4-entry stack (SW=2).
module tb_dad_mem_stack;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int SW = 2;

  logic            clock = 1'b0;
  logic            reset;
  logic [AW-1:0]   address;
  logic [DW-1:0]   D_escrita;
  logic            write, read, push, pop, otflag, saida_ack;
  logic [DW-1:0]   dados_lidos, dados_stack, saida;
  logic            saida_valid, stack_full, stack_empty;
  logic [SW:0]     sp;
  logic [2:0]      err;
`ifdef DAD_MEM_BYTE_EN
  logic [DW/8-1:0] be;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  dad_mem_stack #(.DW(DW), .AW(AW), .SW(SW)) dut (
    .clock       (clock),
    .reset       (reset),
    .address     (address),
    .D_escrita   (D_escrita),
    .write       (write),
    .read        (read),
    .push        (push),
    .pop         (pop),
    .otflag      (otflag),
    .saida_ack   (saida_ack),
`ifdef DAD_MEM_BYTE_EN
    .be          (be),
`endif
    .dados_lidos (dados_lidos),
    .dados_stack (dados_stack),
    .saida       (saida),
    .saida_valid (saida_valid),
    .sp          (sp),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .err         (err)
  );

  task automatic idle_inputs();
    write = 0; read = 0; push = 0; pop = 0; otflag = 0; saida_ack = 0;
    address = '0; D_escrita = '0;
`ifdef DAD_MEM_BYTE_EN
    be = '1;
`endif
  endtask

  // One clock with the currently driven inputs, then return inputs to idle.
  task automatic tick();
    @(posedge clock);
    #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    reset = 0;
    tick();
    reset = 1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (dados_lidos !== 32'h0) begin fails++; $display("FAIL reset_lidos got %h exp 0", dados_lidos); end
    tests++; if (dados_stack !== 32'h0) begin fails++; $display("FAIL reset_stack got %h exp 0", dados_stack); end
    tests++; if (saida !== 32'h0 || saida_valid !== 1'b0) begin fails++; $display("FAIL reset_saida got %h/%b exp 0/0", saida, saida_valid); end
    tests++; if (sp !== 3'd0 || stack_empty !== 1'b1 || stack_full !== 1'b0) begin fails++; $display("FAIL reset_sp got sp=%0d e=%b f=%b exp 0/1/0", sp, stack_empty, stack_full); end
    tests++; if (err !== 3'b000) begin fails++; $display("FAIL reset_err got %b exp 000", err); end
  endtask

  task automatic test_data_ram();
    write = 1; address = 12'h010; D_escrita = 32'hDEADBEEF; tick();
    write = 1; address = 12'hFFF; D_escrita = 32'h0BADF00D; tick();
    read = 1; address = 12'h010; tick();
    tests++; if (dados_lidos !== 32'hDEADBEEF) begin fails++; $display("FAIL ram_read got %h exp deadbeef", dados_lidos); end
    write = 1; read = 1; address = 12'h010; D_escrita = 32'h1; tick();
    tests++; if (dados_lidos !== 32'hDEADBEEF) begin fails++; $display("FAIL ram_rbw got %h exp deadbeef", dados_lidos); end
    read = 1; address = 12'h010; tick();
    tests++; if (dados_lidos !== 32'h1) begin fails++; $display("FAIL ram_newval got %h exp 1", dados_lidos); end
    address = 12'hFFF; tick();
    tests++; if (dados_lidos !== 32'h1) begin fails++; $display("FAIL ram_hold got %h exp 1", dados_lidos); end
    read = 1; address = 12'hFFF; tick();
    tests++; if (dados_lidos !== 32'h0BADF00D) begin fails++; $display("FAIL ram_topaddr got %h exp 0badf00d", dados_lidos); end
  endtask

  task automatic test_stack_order();
    do_reset();
    push = 1; D_escrita = 32'h11; tick();
    push = 1; D_escrita = 32'h22; tick();
    push = 1; D_escrita = 32'h33; tick();
    tests++; if (sp !== 3'd3) begin fails++; $display("FAIL stk_sp3 got %0d exp 3", sp); end
    pop = 1; tick();
    tests++; if (dados_stack !== 32'h33 || sp !== 3'd2) begin fails++; $display("FAIL stk_pop1 got %h sp=%0d exp 33 sp=2", dados_stack, sp); end
    pop = 1; tick();
    tests++; if (dados_stack !== 32'h22 || sp !== 3'd1) begin fails++; $display("FAIL stk_pop2 got %h sp=%0d exp 22 sp=1", dados_stack, sp); end
    pop = 1; tick();
    tests++; if (dados_stack !== 32'h11 || sp !== 3'd0) begin fails++; $display("FAIL stk_pop3 got %h sp=%0d exp 11 sp=0", dados_stack, sp); end
    tick();
    tests++; if (stack_empty !== 1'b1 || err !== 3'b000 || dados_stack !== 32'h11) begin fails++; $display("FAIL stk_end got e=%b err=%b ds=%h exp 1/000/11", stack_empty, err, dados_stack); end
  endtask

  task automatic test_stack_limits();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      push = 1; D_escrita = 32'(i); tick();
    end
    tests++; if (sp !== 3'd4 || stack_full !== 1'b1 || err !== 3'b000) begin fails++; $display("FAIL full_state got sp=%0d f=%b err=%b exp 4/1/000", sp, stack_full, err); end
    push = 1; D_escrita = 32'h5; tick();
    tests++; if (sp !== 3'd4 || err !== 3'b001) begin fails++; $display("FAIL overflow got sp=%0d err=%b exp 4/001", sp, err); end
    for (int i = 4; i >= 1; i--) begin
      pop = 1; tick();
      tests++; if (dados_stack !== 32'(i)) begin fails++; $display("FAIL drain_%0d got %h exp %h", i, dados_stack, 32'(i)); end
    end
    pop = 1; tick();
    tests++; if (dados_stack !== 32'h1 || sp !== 3'd0 || err !== 3'b011) begin fails++; $display("FAIL underflow got ds=%h sp=%0d err=%b exp 1/0/011", dados_stack, sp, err); end
    tick();
    tests++; if (err !== 3'b011) begin fails++; $display("FAIL err_sticky got %b exp 011", err); end
  endtask

  task automatic test_push_pop();
    do_reset();
    push = 1; D_escrita = 32'h99; tick();
    push = 1; D_escrita = 32'hAA; tick();
    push = 1; pop = 1; D_escrita = 32'hBB; tick();
    tests++; if (dados_stack !== 32'hAA || sp !== 3'd2) begin fails++; $display("FAIL pushpop got %h sp=%0d exp aa sp=2", dados_stack, sp); end
    pop = 1; tick();
    tests++; if (dados_stack !== 32'hBB || sp !== 3'd1) begin fails++; $display("FAIL pushpop_next got %h sp=%0d exp bb sp=1", dados_stack, sp); end
    pop = 1; tick();
    tests++; if (dados_stack !== 32'h99 || err !== 3'b000) begin fails++; $display("FAIL pushpop_base got %h err=%b exp 99/000", dados_stack, err); end
    // push+pop on an empty stack: only the push happens
    push = 1; pop = 1; D_escrita = 32'h77; tick();
    tests++; if (sp !== 3'd1 || err !== 3'b010 || dados_stack !== 32'h99) begin fails++; $display("FAIL pushpop_empty got sp=%0d err=%b ds=%h exp 1/010/99", sp, err, dados_stack); end
    pop = 1; tick();
    tests++; if (dados_stack !== 32'h77 || sp !== 3'd0) begin fails++; $display("FAIL pushpop_empty_pop got %h sp=%0d exp 77 sp=0", dados_stack, sp); end
  endtask

  task automatic test_outport();
    do_reset();
    saida_ack = 1; tick();
    tests++; if (saida_valid !== 1'b0 || saida !== 32'h0) begin fails++; $display("FAIL out_ack_idle got %b/%h exp 0/0", saida_valid, saida); end
    otflag = 1; D_escrita = 32'h5; tick();
    tests++; if (saida !== 32'h5 || saida_valid !== 1'b1) begin fails++; $display("FAIL out_load got %h/%b exp 5/1", saida, saida_valid); end
    otflag = 1; D_escrita = 32'h6; tick();
    tests++; if (saida !== 32'h5 || saida_valid !== 1'b1 || err !== 3'b100) begin fails++; $display("FAIL out_drop got %h/%b err=%b exp 5/1/100", saida, saida_valid, err); end
    otflag = 1; saida_ack = 1; D_escrita = 32'h7; tick();
    tests++; if (saida !== 32'h7 || saida_valid !== 1'b1) begin fails++; $display("FAIL out_ackload got %h/%b exp 7/1", saida, saida_valid); end
    saida_ack = 1; tick();
    tests++; if (saida !== 32'h7 || saida_valid !== 1'b0 || err !== 3'b100) begin fails++; $display("FAIL out_ack got %h/%b err=%b exp 7/0/100", saida, saida_valid, err); end
  endtask

  task automatic test_reset_mid();
    write = 1; address = 12'h020; D_escrita = 32'hCAFE; tick();
    push = 1; D_escrita = 32'h44; tick();
    pop = 1; tick();
    tests++; if (err !== 3'b100 || sp !== 3'd0 || dados_stack !== 32'h44) begin fails++; $display("FAIL pre_mid got err=%b sp=%0d ds=%h exp 100/0/44", err, sp, dados_stack); end
    reset = 0; push = 1; otflag = 1; write = 1; address = 12'h020; D_escrita = 32'h1234; tick();
    reset = 1;
    tests++; if (sp !== 3'd0 || saida_valid !== 1'b0 || err !== 3'b000 || dados_stack !== 32'h0) begin fails++; $display("FAIL mid_reset got sp=%0d v=%b err=%b ds=%h exp 0/0/000/0", sp, saida_valid, err, dados_stack); end
    read = 1; address = 12'h020; tick();
    tests++; if (dados_lidos !== 32'hCAFE) begin fails++; $display("FAIL mid_reset_write got %h exp cafe", dados_lidos); end
  endtask

`ifdef DAD_MEM_BYTE_EN
  task automatic test_byte_en();
    write = 1; address = 12'h030; D_escrita = 32'h0; be = 4'hF; tick();
    write = 1; address = 12'h030; D_escrita = 32'hFFFFFFFF; be = 4'b0010; tick();
    read = 1; address = 12'h030; tick();
    tests++; if (dados_lidos !== 32'h0000FF00) begin fails++; $display("FAIL be_lane got %h exp 0000ff00", dados_lidos); end
    write = 1; address = 12'h030; D_escrita = 32'h12345678; be = 4'b0000; tick();
    read = 1; address = 12'h030; tick();
    tests++; if (dados_lidos !== 32'h0000FF00) begin fails++; $display("FAIL be_none got %h exp 0000ff00", dados_lidos); end
  endtask
`endif

  initial begin
    idle_inputs();
    reset = 0;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_data_ram();
    test_stack_order();
    test_stack_limits();
    test_push_pop();
    test_outport();
    test_reset_mid();
`ifdef DAD_MEM_BYTE_EN
    test_byte_en();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
